// File: rtl/crop_pkg.sv
// Frame geometry defaults and FSM state encoding for the crop_window slice.
package crop_pkg;

    localparam int FRAME_W = 640;
    localparam int FRAME_H = 480;
    localparam int CNT_W   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } crop_state_t;

endpackage

// File: rtl/crop_window_pixel_counter.sv
// Raster x/y counters that advance on accepted pixels, plus first/last-pixel flags.
module pixel_counter
    import crop_pkg::*;
#(
    parameter int H_ACTIVE = FRAME_W,
    parameter int V_ACTIVE = FRAME_H
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iEN,
    output logic [CNT_W-1:0] oX,
    output logic [CNT_W-1:0] oY,
    output logic             oFIRST,
    output logic             oLAST
);

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_x <= '0;
            r_y <= '0;
        end else if (iEN) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                if (r_y == Y_LAST) begin
                    r_y <= '0;
                end else begin
                    r_y <= r_y + 1'b1;
                end
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign oX     = r_x;
    assign oY     = r_y;
    assign oFIRST = (r_x == '0) && (r_y == '0);
    assign oLAST  = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/crop_window.sv
// Crops a fixed-width, vertically positioned window out of a raster pixel stream.
// Optional CROP_WINDOW_CLAMP_EN keeps the window fully inside the frame.
module crop_window
    import crop_pkg::*;
#(
    parameter int H_ACTIVE = FRAME_W,
    parameter int V_ACTIVE = FRAME_H,
    parameter int X_START  = 160,
    parameter int CROP_W   = 320,
    parameter int CROP_H   = 240
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic [9:0]  iDATA,
    input  logic [15:0] iYSTART,
    output logic        oDVAL,
    output logic [9:0]  oDATA,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic        oFRAME_DONE
);

    localparam logic [16:0] X_LO   = 17'(X_START);
    localparam logic [16:0] X_HI   = 17'(X_START + CROP_W);
    localparam logic [16:0] Y_SPAN = 17'(CROP_H);
    localparam logic [15:0] X_OFS  = 16'(X_START);

    logic [15:0]  w_x;
    logic [15:0]  w_y;
    logic         w_first;
    logic         w_last;
    crop_state_t  r_state;
    crop_state_t  w_stateNext;
    logic         w_latchYs;
    logic [15:0]  w_ysIn;
    logic [15:0]  w_ysCur;
    logic [15:0]  r_ys;
    logic [16:0]  w_x17;
    logic [16:0]  w_y17;
    logic [16:0]  w_ys17;
    logic         w_inWin;
    logic         r_dval;
    logic [9:0]   r_data;
    logic [15:0]  r_ox;
    logic [15:0]  r_oy;
    logic         r_done;

    pixel_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_counter (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iEN    (iDVAL),
        .oX     (w_x),
        .oY     (w_y),
        .oFIRST (w_first),
        .oLAST  (w_last)
    );

`ifdef CROP_WINDOW_CLAMP_EN
    localparam logic [15:0] YS_MAX = 16'(V_ACTIVE - CROP_H);
    assign w_ysIn = (iYSTART > YS_MAX) ? YS_MAX : iYSTART;
`else
    assign w_ysIn = iYSTART;
`endif

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The top-line value is captured on the frame's first pixel, which is also the IDLE exit.
    always_comb begin
        w_stateNext = r_state;
        w_latchYs   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iDVAL) begin
                    w_stateNext = ST_RUN;
                    w_latchYs   = 1'b1;
                end
            end
            ST_RUN: begin
                w_latchYs = iDVAL && w_first;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_ys <= '0;
        end else if (w_latchYs) begin
            r_ys <= w_ysIn;
        end
    end

    // Pixel (0,0) must already see the freshly latched top line.
    assign w_ysCur = w_latchYs ? w_ysIn : r_ys;
    assign w_x17   = {1'b0, w_x};
    assign w_y17   = {1'b0, w_y};
    assign w_ys17  = {1'b0, w_ysCur};
    assign w_inWin = (w_x17 >= X_LO) && (w_x17 < X_HI) &&
                     (w_y17 >= w_ys17) && (w_y17 < (w_ys17 + Y_SPAN));

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_dval <= 1'b0;
            r_data <= '0;
            r_ox   <= '0;
            r_oy   <= '0;
            r_done <= 1'b0;
        end else begin
            r_dval <= iDVAL && w_inWin;
            r_done <= iDVAL && w_last;
            if (iDVAL && w_inWin) begin
                r_data <= iDATA;
                r_ox   <= w_x - X_OFS;
                r_oy   <= w_y - w_ysCur;
            end
        end
    end

    assign oDVAL       = r_dval;
    assign oDATA       = r_data;
    assign oX          = r_ox;
    assign oY          = r_oy;
    assign oFRAME_DONE = r_done;

endmodule

// File: doc/crop_window.md
CROP_WINDOW -- requirements
Module: crop_window

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter X_START, default 160: first cropped column.
REQ-004 Parameter CROP_W, default 320: cropped width in pixels.
REQ-005 Parameter CROP_H, default 240: cropped height in lines.
REQ-006 iCLK  input  1: single clock; all logic on its rising edge.
REQ-007 iRST  input  1: reset, synchronous, active-low.
REQ-008 iDVAL  input  1: input pixel valid; one pixel per asserted cycle, raster order.
REQ-009 iDATA  input  10: input pixel.
REQ-010 iYSTART  input  16: crop top line from the upstream Y-start detector.
REQ-011 oDVAL  output  1: cropped pixel valid.
REQ-012 oDATA  output  10: cropped pixel.
REQ-013 oX  output  16: column within the crop window, 0..CROP_W-1.
REQ-014 oY  output  16: line within the crop window, 0..CROP_H-1.
REQ-015 oFRAME_DONE  output  1: one-cycle pulse after the last input pixel of a frame.

Function
REQ-016 Internal 16-bit counters x and y shall advance only on iDVAL=1 cycles. x increments; at H_ACTIVE-1, x wraps to 0 and y increments; at (H_ACTIVE-1, V_ACTIVE-1), both wrap to 0.
REQ-017 FSM states: IDLE and RUN. Reset enters IDLE. IDLE goes to RUN on the first iDVAL=1 cycle. RUN has no exit except reset.
REQ-018 Register ys shall latch iYSTART on every iDVAL=1 cycle with x=0 and y=0, including the IDLE->RUN cycle. ys shall hold for the whole frame, and mid-frame changes of iYSTART shall be ignored.
REQ-019 An accepted pixel is inside the window when X_START <= x < X_START+CROP_W and ys <= y < ys+CROP_H. The comparisons shall use 17-bit sums so no wrap-around occurs.
REQ-020 Latency is 1 cycle. For an in-window accepted pixel, the next cycle shall show oDVAL=1, oDATA=iDATA, oX=x-X_START, oY=y-ys. Otherwise oDVAL=0 next cycle.
REQ-021 When oDVAL=0, oDATA, oX and oY shall hold their last values.
REQ-022 oFRAME_DONE shall be 1 for exactly the cycle after the pixel at (H_ACTIVE-1, V_ACTIVE-1) is accepted. It shall be independent of the window.
REQ-023 Rows at or beyond V_ACTIVE are never produced, so a window extending past the frame bottom is truncated. This applies unless CROP_WINDOW_CLAMP_EN is defined.
REQ-024 iDVAL gaps of any length shall not alter counters, ys or state.

Reset
REQ-025 When iRST=0 at a clock edge, the following shall clear next cycle: x=0, y=0, ys=0, state=IDLE, oDVAL=0, oDATA=0, oX=0, oY=0, oFRAME_DONE=0.
REQ-026 Reset mid-frame shall discard the partial frame. The next accepted pixel is treated as (0,0) and latches ys.

Configuration
REQ-027 Macro CROP_WINDOW_CLAMP_EN. When defined, a latched iYSTART greater than V_ACTIVE-CROP_H shall be stored as V_ACTIVE-CROP_H. Every frame then yields exactly CROP_W*CROP_H output pixels.
REQ-028 When CROP_WINDOW_CLAMP_EN is undefined, ys shall equal iYSTART unmodified. This gives truncation per REQ-023, and no output for iYSTART >= V_ACTIVE.

Structure
REQ-029 Package crop_pkg shall hold the frame-size constants (640/480) and the FSM state typedef.
REQ-030 Sub-module pixel_counter shall implement the x/y raster counters and the end-of-frame flag. crop_window instantiates it once.

Verification
REQ-031 Reset, then a continuous 640x480 frame with iYSTART=100 -> exactly 76800 oDVAL pulses. The first has oX=0, oY=0 and is 1 cycle after input pixel (160,100). The last has oX=319, oY=239.
REQ-032 iYSTART changes from 100 to 200 at input (300,50) -> the current frame's window stays at lines 100..339. The next frame's window is at lines 200..439.
REQ-033 iYSTART=400, clamp undefined -> 80 lines x 320 = 25600 output pixels. With CROP_WINDOW_CLAMP_EN -> ys=240 and 76800 pixels, the first at input (160,240).
REQ-034 Random iDVAL duty of 30% over one frame -> output pixel values and order are identical to the continuous case. There is one oFRAME_DONE pulse, 1 cycle after pixel (639,479).
REQ-035 iRST=0 for 1 cycle at input (400,150) -> all outputs are 0 next cycle. The following frame starting at the next iDVAL yields a full 76800-pixel window.
